fir_seq_mac: RTL

Time-multiplexed FIR controller: computes the same (N+1)-tap signed FIR as the parallel filter, but sequences all taps through one shared multiplier-accumulator. It owns the sample delay line, the coefficient register file and the MAC schedule. It sits between a valid/ready sample source and a valid/ready sink, for use where multiplier count matters more than throughput.

---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_seq_mac_if.sv | 31 +++
 rtl/fir_delay_line.sv | 40 ++++
 rtl/fir_seq_mac.sv | 109 ++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR controller.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    // Full-precision output width: product bits plus growth over N+1 taps.
    function automatic int out_width(input int w_x, input int w_k, input int n);
        return w_x + w_k + $clog2(n + 1);
    endfunction

    localparam logic signed [3:0] K_INIT_DEF [4] = '{4'sd1, 4'sd1, 4'sd1, 4'sd1};

endpackage

// File: rtl/fir_seq_mac_if.sv
// Sample source, result sink and coefficient write port of fir_seq_mac.
interface fir_seq_mac_if
    import fir_pkg::*;
#(
    parameter int N   = 3,
    parameter int W_X = 4,
    parameter int W_K = 4,
    parameter int W_Y = out_width(W_X, W_K, N),
    parameter int AW  = $clog2(N + 1)
);
    logic signed [W_X-1:0] x_data;
    logic                  x_valid;
    logic                  x_ready;
    logic signed [W_Y-1:0] y_data;
    logic                  y_valid;
    logic                  y_ready;
    logic                  k_wr_en;
    logic [AW-1:0]         k_wr_addr;
    logic signed [W_K-1:0] k_wr_data;
    logic                  busy;

    modport slave (
        input  x_data, x_valid, y_ready, k_wr_en, k_wr_addr, k_wr_data,
        output x_ready, y_data, y_valid, busy
    );

    modport master (
        output x_data, x_valid, y_ready, k_wr_en, k_wr_addr, k_wr_data,
        input  x_ready, y_data, y_valid, busy
    );
endinterface

// File: rtl/fir_delay_line.sv
// Circular sample buffer of N+1 words; the read port is addressed by sample age.
module fir_delay_line #(
    parameter int N   = 3,
    parameter int W_X = 4,
    localparam int AW = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic signed [W_X-1:0] wdata,
    input  logic [AW-1:0]         age,
    output logic signed [W_X-1:0] rdata
);
    logic signed [W_X-1:0] mem [N+1];
    logic [AW-1:0]         head;
    logic [AW:0]           rd_sum;
    logic [AW-1:0]         rd_addr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            // NOTE: the buffer is reset explicitly because filter history must
            // start from zero; a memory that is never reset comes up as X.
            for (int k = 0; k <= N; k++) begin
                mem[k] <= '0;
            end
        end else if (we) begin
            mem[head] <= wdata;
            head      <= (head == AW'(N)) ? '0 : head + 1'b1;
        end
    end

    // Newest sample sits just behind head: addr = (head - 1 - age) mod (N+1).
    assign rd_sum  = {1'b0, head} + (AW+1)'(N) - {1'b0, age};
    assign rd_addr = (rd_sum > (AW+1)'(N)) ? AW'(rd_sum - (AW+1)'(N + 1)) : AW'(rd_sum);
    assign rdata   = mem[rd_addr];

endmodule

// File: rtl/fir_seq_mac.sv
// Sequential FIR: one shared multiplier-accumulator steps through all N+1 taps per sample.
module fir_seq_mac
    import fir_pkg::*;
#(
    parameter int N   = 3,
    parameter int W_X = 4,
    parameter int W_K = 4,
    parameter int W_Y = out_width(W_X, W_K, N),
    parameter logic signed [W_K-1:0] K_INIT [N+1] = K_INIT_DEF
) (
    input logic          clk,
    input logic          rst,
    fir_seq_mac_if.slave bus
);
    localparam int TAPS = N + 1;
    localparam int AW   = $clog2(TAPS);
    localparam int W_P  = W_X + W_K;

    state_t                state, state_nxt;
    logic [AW-1:0]         tap;
    logic signed [W_K-1:0] coef [TAPS];
    logic signed [W_Y-1:0] acc;
    logic signed [W_Y-1:0] y_q;
    logic signed [W_X-1:0] z_tap;
    logic signed [W_P-1:0] prod;
    logic signed [W_Y-1:0] prod_ext;
    logic signed [W_Y-1:0] acc_sum;
    logic                  accept;
    logic                  last_tap;

    fir_delay_line #(.N(N), .W_X(W_X)) u_delay_line (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .wdata (bus.x_data),
        .age   (tap),
        .rdata (z_tap)
    );

    assign accept   = (state == IDLE) && bus.x_valid;
    assign last_tap = (tap == AW'(N));
    assign prod     = W_P'(z_tap) * W_P'(coef[tap]);
    assign prod_ext = {{(W_Y - W_P){prod[W_P-1]}}, prod};
    assign acc_sum  = acc + prod_ext;
    assign bus.y_data = y_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        bus.x_ready = 1'b0;
        bus.y_valid = 1'b0;
        bus.busy    = 1'b1;
        case (state)
            IDLE: begin
                bus.x_ready = 1'b1;
                bus.busy    = 1'b0;
                if (bus.x_valid) state_nxt = MAC;
            end
            MAC: begin
                if (last_tap) state_nxt = OUT;
            end
            OUT: begin
                bus.y_valid = 1'b1;
                if (bus.y_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            tap <= '0;
            y_q <= '0;
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= K_INIT[k];
            end
        end else begin
            // Coefficients change only between samples; writes while busy are dropped.
            if (state == IDLE && bus.k_wr_en && int'(bus.k_wr_addr) < TAPS) begin
                coef[bus.k_wr_addr] <= bus.k_wr_data;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= '0;
                        tap <= '0;
                    end
                end
                MAC: begin
                    if (last_tap) begin
                        y_q <= acc_sum;
                    end else begin
                        acc <= acc_sum;
                        tap <= tap + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
